// File: rtl/datapath_acumulador.sv
// SAP-1 accumulator datapath: A/B registers, adder/subtractor with flags,
// W bus drive with contention detect, OUT register and 2-digit hex display scan.
module datapath_acumulador #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [WIDTH-1:0] w_bus_in,
    input  logic             La_barra,
    input  logic             Ea,
    input  logic             Su,
    input  logic             Eu,
    input  logic             Lb_barra,
    input  logic             Lo_barra,
    output logic [WIDTH-1:0] w_bus_out,
    output logic             w_bus_oe,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] out_reg,
    output logic             carry,
    output logic             zero,
    output logic             bus_conflict,
    output logic [1:0]       dig_sel,
    output logic [6:0]       seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {DIG0, DIG1} digit_e;

    logic [WIDTH-1:0] a_reg, b_reg, o_reg;
    logic [WIDTH-1:0] b_op, sum;
    logic [WIDTH:0]   alu_full;
    logic             cout;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_wrap;
    logic [3:0]       nibble;
    digit_e           state, state_nxt;

    // Subtract is A + ~B + 1, so cout high means no borrow
    always_comb begin
        b_op     = Su ? ~b_reg : b_reg;
        alu_full = {1'b0, a_reg} + {1'b0, b_op} + {{WIDTH{1'b0}}, Su};
    end

    assign sum  = alu_full[WIDTH-1:0];
    assign cout = alu_full[WIDTH];

    always_comb begin
        w_bus_oe = Ea | Eu;
        if (Ea)
            w_bus_out = a_reg;
        else if (Eu)
            w_bus_out = sum;
        else
            w_bus_out = '0;
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            a_reg        <= '0;
            b_reg        <= '0;
            o_reg        <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (!La_barra) a_reg <= w_bus_in;
            if (!Lb_barra) b_reg <= w_bus_in;
            if (!Lo_barra) o_reg <= w_bus_in;
            // Flags track only ALU results written back into A
            if (!La_barra && Eu) begin
                carry <= cout;
                zero  <= (sum == '0);
            end
            if (Ea && Eu) bus_conflict <= 1'b1;
        end
    end

    assign acc     = a_reg;
    assign out_reg = o_reg;

    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            scan_cnt <= '0;
            state    <= DIG0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            state    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (scan_wrap)
            state_nxt = (state == DIG0) ? DIG1 : DIG0;
    end

    always_comb begin
        dig_sel = 2'b10;
        nibble  = o_reg[3:0];
        if (state == DIG1) begin
            dig_sel = 2'b01;
            nibble  = o_reg[7:4];
        end
    end

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_datapath_acumulador.sv
// Scoreboard bench for datapath_acumulador: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_acumulador;

    localparam int W  = 8;
    localparam int SD = 4;

    logic         clock = 1'b0;
    logic         clr;
    logic [W-1:0] ext_bus;
    logic [W-1:0] w_bus_in;
    logic         La_barra, Ea, Su, Eu, Lb_barra, Lo_barra;
    logic [W-1:0] w_bus_out, acc, out_reg;
    logic         w_bus_oe, carry, zero, bus_conflict;
    logic [1:0]   dig_sel;
    logic [6:0]   seg;

    int tests  = 0;
    int failed = 0;
    int edges  = 0;

    typedef enum int {S_ACC, S_OUT, S_CARRY, S_ZERO, S_CONF, S_DIG, S_SEG, S_BUS, S_OE} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // The bench resolves the W bus: DUT drive wins, otherwise memory/ext value
    assign w_bus_in = w_bus_oe ? w_bus_out : ext_bus;

    datapath_acumulador #(.WIDTH(W), .SCAN_DIV(SD)) dut (
        .clock        (clock),
        .clr          (clr),
        .w_bus_in     (w_bus_in),
        .La_barra     (La_barra),
        .Ea           (Ea),
        .Su           (Su),
        .Eu           (Eu),
        .Lb_barra     (Lb_barra),
        .Lo_barra     (Lo_barra),
        .w_bus_out    (w_bus_out),
        .w_bus_oe     (w_bus_oe),
        .acc          (acc),
        .out_reg      (out_reg),
        .carry        (carry),
        .zero         (zero),
        .bus_conflict (bus_conflict),
        .dig_sel      (dig_sel),
        .seg          (seg)
    );

    always #5 clock = ~clock;

    // Edges since reset release, used to predict the display scan phase
    always @(posedge clock or negedge clr) begin
        if (!clr) edges <= 0;
        else      edges <= edges + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            S_ACC:   return 32'(acc);
            S_OUT:   return 32'(out_reg);
            S_CARRY: return 32'(carry);
            S_ZERO:  return 32'(zero);
            S_CONF:  return 32'(bus_conflict);
            S_DIG:   return 32'(dig_sel);
            S_SEG:   return 32'(seg);
            S_BUS:   return 32'(w_bus_out);
            S_OE:    return 32'(w_bus_oe);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sig);
            tests++;
            if (a !== e.exp) begin
                failed++;
                $display("FAIL %s: got %h, required %h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_v(input string n, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_now();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        La_barra = 1'b1; Lb_barra = 1'b1; Lo_barra = 1'b1;
        Ea = 1'b0; Eu = 1'b0; Su = 1'b0; ext_bus = '0;
    endtask

    task automatic load(input logic la, input logic lb, input logic lo, input logic [W-1:0] v);
        ext_bus = v; La_barra = la; Lb_barra = lb; Lo_barra = lo;
        tick();
        idle();
    endtask

    task automatic alu_into_a(input logic su);
        Su = su; Eu = 1'b1; La_barra = 1'b0;
        tick();
        idle();
    endtask

    task automatic expect_reset(input string tag);
        expect_v({tag, "_acc"},   S_ACC,   32'h00);
        expect_v({tag, "_out"},   S_OUT,   32'h00);
        expect_v({tag, "_carry"}, S_CARRY, 32'h0);
        expect_v({tag, "_zero"},  S_ZERO,  32'h0);
        expect_v({tag, "_conf"},  S_CONF,  32'h0);
        expect_v({tag, "_dig"},   S_DIG,   32'h2);
        expect_v({tag, "_seg"},   S_SEG,   32'h40);
    endtask

    task automatic expect_alu(input string tag, input logic [7:0] a, input logic c, input logic z);
        expect_v({tag, "_acc"},   S_ACC,   32'(a));
        expect_v({tag, "_carry"}, S_CARRY, 32'(c));
        expect_v({tag, "_zero"},  S_ZERO,  32'(z));
    endtask

    initial begin
        clr = 1'b0;
        idle();
        repeat (3) @(posedge clock);
        #1;
        expect_reset("por");
        check_now();
        clr = 1'b1;
        tick();

        // 0x14 + 0x2D = 0x41
        load(1'b0, 1'b1, 1'b1, 8'h14);
        load(1'b1, 1'b0, 1'b1, 8'h2D);
        Eu = 1'b1;
        expect_v("add_bus", S_BUS, 32'h41);
        expect_v("add_oe",  S_OE,  32'h1);
        check_now();
        alu_into_a(1'b0);
        expect_alu("add", 8'h41, 1'b0, 1'b0);
        check_now();

        // 0xF0 + 0x20 wraps to 0x10 with carry
        load(1'b0, 1'b1, 1'b1, 8'hF0);
        load(1'b1, 1'b0, 1'b1, 8'h20);
        alu_into_a(1'b0);
        expect_alu("ovf", 8'h10, 1'b1, 1'b0);
        check_now();

        // 0x07 - 0x07 = 0, no borrow
        load(1'b0, 1'b1, 1'b1, 8'h07);
        load(1'b1, 1'b0, 1'b1, 8'h07);
        alu_into_a(1'b1);
        expect_alu("sub_eq", 8'h00, 1'b1, 1'b1);
        check_now();

        // Memory load of A leaves flags alone
        load(1'b0, 1'b1, 1'b1, 8'h80);
        expect_alu("hold", 8'h80, 1'b1, 1'b1);
        check_now();

        // 0x00 - 0x01 = 0xFF with borrow
        load(1'b0, 1'b1, 1'b1, 8'h00);
        load(1'b1, 1'b0, 1'b1, 8'h01);
        alu_into_a(1'b1);
        expect_alu("sub_brw", 8'hFF, 1'b0, 1'b0);
        check_now();

        // Eu alone drives sum; Ea+Eu drives A and latches the conflict flag
        load(1'b0, 1'b1, 1'b1, 8'h33);
        Eu = 1'b1;
        expect_v("eu_bus",  S_BUS,  32'h34);
        expect_v("eu_conf", S_CONF, 32'h0);
        check_now();
        Ea = 1'b1;
        expect_v("conf_bus", S_BUS, 32'h33);
        expect_v("conf_oe",  S_OE,  32'h1);
        check_now();
        tick();
        idle();
        expect_v("conf_set", S_CONF, 32'h1);
        expect_v("idle_oe",  S_OE,   32'h0);
        expect_v("idle_bus", S_BUS,  32'h00);
        check_now();
        repeat (3) tick();
        expect_v("conf_sticky", S_CONF, 32'h1);
        check_now();

        // Simultaneous loads of A, B and OUT on one edge
        load(1'b0, 1'b0, 1'b0, 8'h55);
        expect_v("multi_acc", S_ACC, 32'h55);
        expect_v("multi_out", S_OUT, 32'h55);
        Eu = 1'b1;
        expect_v("multi_sum", S_BUS, 32'hAA);
        check_now();

        // Asynchronous clear mid-scan, checked before any further clock edge
        Eu = 1'b0;
        tick();
        clr = 1'b0;
        Eu  = 1'b1;
        expect_reset("arst");
        expect_v("arst_oe",  S_OE,  32'h1);
        expect_v("arst_bus", S_BUS, 32'h00);
        check_now();
        idle();
        clr = 1'b1;

        // OUT = 0x5A via Ea, then watch the scan with SCAN_DIV = 4
        load(1'b0, 1'b1, 1'b1, 8'h5A);
        Ea = 1'b1; Lo_barra = 1'b0;
        tick();
        idle();
        expect_v("out_val", S_OUT, 32'h5A);
        for (int i = 0; i < 10; i++) begin
            if (((edges / SD) % 2) == 0) begin
                expect_v("scan_dig", S_DIG, 32'h2);
                expect_v("scan_seg", S_SEG, 32'h08);
            end else begin
                expect_v("scan_dig", S_DIG, 32'h1);
                expect_v("scan_seg", S_SEG, 32'h12);
            end
            check_now();
            tick();
        end

        check_now();
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
